hilo_mdu_ctrl: RTL and testbench

Multiply/divide sequencer for the HI/LO register pair in the EX stage of the MIPS core. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs an iterative multiplier and divider. Stalls the pipeline while an operation is in flight, then issues a single write strobe plus 64-bit data to the HI/LO register. That register captures on the falling edge of the same cycle.

---
 rtl/hilo_mdu_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_hilo_mdu_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl: HI/LO multiply/divide sequencer for the EX stage.
// Runs MULT/MULTU/DIV/DIVU iteratively while stalling the pipeline, then
// issues one hilo_we strobe carrying {HI,LO}. MTHI/MTLO write in the same
// cycle from IDLE without stalling.
// Optional build macro: MDU_FAST_MUL_EN selects a single-cycle registered
// 64-bit multiply instead of the 32-step shift-add multiplier.
module hilo_mdu_ctrl #(
   parameter int DIV_ITERS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic [63:0] hilo_cur,
   output logic        stall,
   output logic        busy,
   output logic        hilo_we,
   output logic [63:0] hilo_wdata
);

   localparam int CW = $clog2(DIV_ITERS);
   localparam logic [CW-1:0] LAST_ITER = CW'(DIV_ITERS - 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t         state_reg, state_next;
   // hi/lo hold the running product (mul) or remainder/quotient (div);
   // b holds the multiplicand or divisor magnitude.
   logic [31:0]    hi_reg, hi_next;
   logic [31:0]    lo_reg, lo_next;
   logic [31:0]    b_reg, b_next;
   logic [CW-1:0]  count_reg, count_next;
   logic           neg_q_reg, neg_q_next;   // negate product / quotient
   logic           neg_r_reg, neg_r_next;   // negate remainder
   logic [63:0]    res_reg, res_next;       // result presented in DONE

   // Instruction decode (op 0 and 7 are both treated as NOP)
   logic is_mul, is_div, is_signed, is_mthi, is_mtlo;
   logic [31:0] mag_a, mag_b;

   assign is_mul    = op_valid && (op == 3'd1 || op == 3'd2);
   assign is_div    = op_valid && (op == 3'd3 || op == 3'd4);
   assign is_signed = (op == 3'd1 || op == 3'd3);
   assign is_mthi   = op_valid && (op == 3'd5);
   assign is_mtlo   = op_valid && (op == 3'd6);
   assign mag_a     = (is_signed && rs_data[31]) ? (-rs_data) : rs_data;
   assign mag_b     = (is_signed && rt_data[31]) ? (-rt_data) : rt_data;

   // Restoring divide step: 33-bit shifted remainder against the divisor;
   // a 34-bit difference exposes the borrow.
   logic [32:0] div_shift;
   logic [33:0] div_trial;
   logic        div_ge;
   logic [31:0] div_rem, div_quo, div_rem_fin, div_quo_fin;

   assign div_shift   = {hi_reg, lo_reg[31]};
   assign div_trial   = {1'b0, div_shift} - {2'b00, b_reg};
   assign div_ge      = ~div_trial[33];
   assign div_rem     = div_ge ? div_trial[31:0] : div_shift[31:0];
   assign div_quo     = {lo_reg[30:0], div_ge};
   assign div_rem_fin = neg_r_reg ? (-div_rem) : div_rem;
   assign div_quo_fin = neg_q_reg ? (-div_quo) : div_quo;

`ifdef MDU_FAST_MUL_EN
   // Single-cycle product of magnitudes; sign restored afterwards
   logic [63:0] fast_prod;
   assign fast_prod = 64'(lo_reg) * 64'(b_reg);
`else
   // Shift-add step: conditionally add multiplicand to the upper half,
   // then shift the whole 64-bit accumulator right by one.
   logic [32:0] mul_sum;
   logic [63:0] mul_prod;
   assign mul_sum  = {1'b0, hi_reg} + {1'b0, b_reg};
   assign mul_prod = lo_reg[0] ? {mul_sum, lo_reg[31:1]}
                               : {1'b0, hi_reg, lo_reg[31:1]};
`endif

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         hi_reg    <= '0;
         lo_reg    <= '0;
         b_reg     <= '0;
         count_reg <= '0;
         neg_q_reg <= 1'b0;
         neg_r_reg <= 1'b0;
         res_reg   <= '0;
      end else begin
         state_reg <= state_next;
         hi_reg    <= hi_next;
         lo_reg    <= lo_next;
         b_reg     <= b_next;
         count_reg <= count_next;
         neg_q_reg <= neg_q_next;
         neg_r_reg <= neg_r_next;
         res_reg   <= res_next;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_next = state_reg;
      hi_next    = hi_reg;
      lo_next    = lo_reg;
      b_next     = b_reg;
      count_next = count_reg;
      neg_q_next = neg_q_reg;
      neg_r_next = neg_r_reg;
      res_next   = res_reg;

      case (state_reg)
         S_IDLE: begin
            if (is_mul || is_div) begin
               hi_next    = '0;
               lo_next    = mag_a;
               b_next     = mag_b;
               count_next = '0;
               neg_q_next = is_signed && (rs_data[31] ^ rt_data[31]);
               neg_r_next = is_signed && rs_data[31];
               if (is_mul) begin
                  state_next = S_MUL;
               end else if (rt_data == 32'd0) begin
                  // Divide by zero bypasses the iterations entirely
                  res_next   = {rs_data, 32'hFFFF_FFFF};
                  state_next = S_DONE;
               end else begin
                  state_next = S_DIV;
               end
            end
         end
         S_MUL: begin
`ifdef MDU_FAST_MUL_EN
            res_next   = neg_q_reg ? (-fast_prod) : fast_prod;
            state_next = S_DONE;
`else
            {hi_next, lo_next} = mul_prod;
            count_next = count_reg + CW'(1);
            if (count_reg == LAST_ITER) begin
               res_next   = neg_q_reg ? (-mul_prod) : mul_prod;
               state_next = S_DONE;
            end
`endif
         end
         S_DIV: begin
            hi_next    = div_rem;
            lo_next    = div_quo;
            count_next = count_reg + CW'(1);
            if (count_reg == LAST_ITER) begin
               res_next   = {div_rem_fin, div_quo_fin};
               state_next = S_DONE;
            end
         end
         default: begin
            // DONE: the EX instruction is the one just finished; ignore it
            state_next = S_IDLE;
         end
      endcase

      if (flush) begin
         state_next = S_IDLE;
      end
   end

   // Pipeline-facing outputs; flush (and reset) silence stall and write
   always_comb begin
      stall      = 1'b0;
      hilo_we    = 1'b0;
      hilo_wdata = '0;
      if (!rst && !flush) begin
         case (state_reg)
            S_IDLE: begin
               if (is_mul || is_div) begin
                  stall = 1'b1;
               end else if (is_mthi) begin
                  hilo_we    = 1'b1;
                  hilo_wdata = {rs_data, hilo_cur[31:0]};
               end else if (is_mtlo) begin
                  hilo_we    = 1'b1;
                  hilo_wdata = {hilo_cur[63:32], rs_data};
               end
            end
            S_MUL, S_DIV: stall = 1'b1;
            default: begin
               hilo_we    = 1'b1;
               hilo_wdata = res_reg;
            end
         endcase
      end
   end

   assign busy = (state_reg != S_IDLE);

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Testbench for hilo_mdu_ctrl: table of operations with scoreboarded
// write data and stall-length checks, plus flush and reset sequences.
module tb_hilo_mdu_ctrl;

`ifdef MDU_FAST_MUL_EN
   localparam int MUL_STALL = 2;
`else
   localparam int MUL_STALL = 33;
`endif
   localparam int DIV_STALL = 33;

   logic        clk = 1'b0;
   logic        rst, flush, op_valid;
   logic [2:0]  op;
   logic [31:0] rs_data, rt_data;
   logic [63:0] hilo_cur;
   logic        stall, busy, hilo_we;
   logic [63:0] hilo_wdata;

   always #5 clk = ~clk;

   hilo_mdu_ctrl dut (
      .clk(clk), .rst(rst), .flush(flush), .op_valid(op_valid), .op(op),
      .rs_data(rs_data), .rt_data(rt_data), .hilo_cur(hilo_cur),
      .stall(stall), .busy(busy), .hilo_we(hilo_we), .hilo_wdata(hilo_wdata)
   );

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [63:0] cur;
      int          n_stall;
      logic [63:0] exp;
   } vec_t;

   vec_t        vecs[$];
   logic [63:0] sb_q[$];
   int          checks = 0;
   int          failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
      else $display("ok   %s = %h", name, act);
   endtask

   task automatic add_vec(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] cur, input int ns,
                          input logic [63:0] e);
      vec_t v;
      v.name = name; v.op = o; v.rs = a; v.rt = b; v.cur = cur; v.n_stall = ns; v.exp = e;
      vecs.push_back(v);
   endtask

   // Drive one op at the next negedge, keep it held (as a stalled EX
   // would) until the write strobe, and count stall cycles before it.
   task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] cur, input int exp_stall,
                         input logic [63:0] exp_data);
      int          n = 0;
      bit          seen = 0;
      logic [63:0] e;
      @(negedge clk);
      op_valid = 1'b1; op = o; rs_data = a; rt_data = b; hilo_cur = cur;
      sb_q.push_back(exp_data);
      for (int c = 0; c < 100; c++) begin
         #1;
         if (hilo_we) begin
            if (sb_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL %s unexpected_we actual=%h required=none", name, hilo_wdata);
            end else begin
               e = sb_q.pop_front();
               check({name, " wdata"}, hilo_wdata, e);
            end
            check({name, " stall_at_we"}, 64'(stall), 64'd0);
            seen = 1;
            break;
         end
         if (stall) n++;
         @(negedge clk);
      end
      if (!seen) begin
         checks++; failures++;
         $display("FAIL %s timeout actual=no_we required=we", name);
         sb_q.delete();
      end
      check({name, " stall_cycles"}, 64'(n), 64'(exp_stall));
   endtask

   task automatic idle_check(input string name);
      @(negedge clk);
      op_valid = 1'b0; op = 3'd0;
      #1;
      check({name, " idle_busy"}, 64'(busy), 64'd0);
      check({name, " idle_we"}, 64'(hilo_we), 64'd0);
   endtask

   initial begin
      int  we_cnt;
      rst = 1'b1; flush = 1'b0; op_valid = 1'b0; op = 3'd0;
      rs_data = '0; rt_data = '0; hilo_cur = '0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("reset stall", 64'(stall), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset we", 64'(hilo_we), 64'd0);
      check("reset wdata", hilo_wdata, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      add_vec("MULT -3x5",      3'd1, 32'hFFFF_FFFD, 32'd5,        64'd0, MUL_STALL, 64'hFFFF_FFFF_FFFF_FFF1);
      add_vec("MULTU max",      3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, MUL_STALL, 64'hFFFF_FFFE_0000_0001);
      add_vec("MULT 7x-2",      3'd1, 32'd7,        32'hFFFF_FFFE, 64'd0, MUL_STALL, 64'hFFFF_FFFF_FFFF_FFF2);
      add_vec("MULT min^2",     3'd1, 32'h8000_0000, 32'h8000_0000, 64'd0, MUL_STALL, 64'h4000_0000_0000_0000);
      add_vec("DIVU 100/7",     3'd4, 32'd100,      32'd7,        64'd0, DIV_STALL, 64'h0000_0002_0000_000E);
      add_vec("DIV -7/2",       3'd3, 32'hFFFF_FFF9, 32'd2,        64'd0, DIV_STALL, 64'hFFFF_FFFF_FFFF_FFFD);
      add_vec("DIV 7/-2",       3'd3, 32'd7,        32'hFFFF_FFFE, 64'd0, DIV_STALL, 64'h0000_0001_FFFF_FFFD);
      add_vec("DIV min/-1",     3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, DIV_STALL, 64'h0000_0000_8000_0000);
      add_vec("DIVU max/10",    3'd4, 32'hFFFF_FFFF, 32'd10,       64'd0, DIV_STALL, 64'h0000_0005_1999_9999);
      add_vec("DIVU 9/0",       3'd4, 32'd9,        32'd0,        64'd0, 1,         64'h0000_0009_FFFF_FFFF);
      add_vec("DIV 5/0",        3'd3, 32'd5,        32'd0,        64'd0, 1,         64'h0000_0005_FFFF_FFFF);
      add_vec("MTHI",           3'd5, 32'hDEAD_BEEF, 32'd0, 64'h1111_1111_2222_2222, 0, 64'hDEAD_BEEF_2222_2222);
      add_vec("MTLO",           3'd6, 32'hDEAD_BEEF, 32'd0, 64'h1111_1111_2222_2222, 0, 64'h1111_1111_DEAD_BEEF);

      foreach (vecs[i]) begin
         run_op(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].cur,
                vecs[i].n_stall, vecs[i].exp);
         idle_check(vecs[i].name);
      end

      // Flush at T10 of a DIVU: no write ever, stall drops in the flush cycle
      we_cnt = 0;
      @(negedge clk);
      op_valid = 1'b1; op = 3'd4; rs_data = 32'd100; rt_data = 32'd7;
      #1; we_cnt += int'(hilo_we);
      for (int t = 1; t < 10; t++) begin
         @(negedge clk); #1; we_cnt += int'(hilo_we);
      end
      check("flush T9 stall", 64'(stall), 64'd1);
      @(negedge clk);
      flush = 1'b1;
      #1;
      we_cnt += int'(hilo_we);
      check("flush T10 stall", 64'(stall), 64'd0);
      @(negedge clk);
      flush = 1'b0; op_valid = 1'b0;
      #1;
      check("flush T11 busy", 64'(busy), 64'd0);
      for (int t = 0; t < 40; t++) begin
         @(negedge clk); #1; we_cnt += int'(hilo_we);
      end
      check("flush no we", 64'(we_cnt), 64'd0);
      run_op("MULTU 3x4 after flush", 3'd2, 32'd3, 32'd4, 64'd0, MUL_STALL, 64'hC);
      idle_check("MULTU after flush");

      // Flush drops a same-cycle MTHI
      @(negedge clk);
      flush = 1'b1; op_valid = 1'b1; op = 3'd5; rs_data = 32'hCAFE_F00D;
      #1;
      check("flush MTHI we", 64'(hilo_we), 64'd0);
      @(negedge clk);
      flush = 1'b0; op_valid = 1'b0; op = 3'd0;

      // Reset at T5 of a MULT
      we_cnt = 0;
      @(negedge clk);
      op_valid = 1'b1; op = 3'd1; rs_data = 32'hFFFF_FFFD; rt_data = 32'd5;
      #1; we_cnt += int'(hilo_we);
      for (int t = 1; t < 5; t++) begin
         @(negedge clk); #1; we_cnt += int'(hilo_we);
      end
      @(negedge clk);
      rst = 1'b1;
      #1; we_cnt += int'(hilo_we);
      @(negedge clk);
      rst = 1'b0; op_valid = 1'b0; op = 3'd0;
      #1;
      check("rst T6 stall", 64'(stall), 64'd0);
      check("rst T6 busy", 64'(busy), 64'd0);
      check("rst T6 we", 64'(hilo_we + 1'(we_cnt != 0)), 64'd0);
      check("rst T6 wdata", hilo_wdata, 64'd0);

      // Back-to-back DIVU then MULTU, the second accepted right after DONE
      run_op("b2b DIVU 100/7", 3'd4, 32'd100, 32'd7, 64'd0, DIV_STALL, 64'h0000_0002_0000_000E);
      run_op("b2b MULTU 3x4", 3'd2, 32'd3, 32'd4, 64'd0, MUL_STALL, 64'hC);
      idle_check("b2b");
      check("scoreboard empty", 64'(sb_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
